// File: rtl/addsub_rr_arbiter.sv
// Round-robin arbiter sharing one 64-bit add/sub datapath among NUM_REQ requesters.
// At most one operation is in flight: accept -> execute -> respond.
module addsub_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_op,
  input  logic [NUM_REQ*64-1:0] req_a,
  input  logic [NUM_REQ*64-1:0] req_b,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [63:0]           rsp_data,
  output logic [63:0]           alu_inA,
  output logic [63:0]           alu_inB,
  output logic                  alu_control,
  input  logic [63:0]           alu_out,
  output logic                  busy,
  output logic [IDW-1:0]        grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] rr_next;
  logic           found;
  logic           accept;
  logic [63:0]    a_arr [NUM_REQ];
  logic [63:0]    b_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[64*i +: 64];
    assign b_arr[i] = req_b[64*i +: 64];
  end

  // First valid requester starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign rr_next = IDW'((int'(winner) + 1) % NUM_REQ);
  assign accept  = (state == IDLE) && found;
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    case (state)
      IDLE: begin
        if (found) begin
          req_ready[winner] = 1'b1;
          state_nxt         = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_valid[grant_id] = 1'b1;
        if (rsp_ready[grant_id]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      alu_inA     <= '0;
      alu_inB     <= '0;
      alu_control <= 1'b0;
      rsp_data    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        alu_inA     <= a_arr[winner];
        alu_inB     <= b_arr[winner];
        alu_control <= req_op[winner];
        grant_id    <= winner;
        rr_ptr      <= rr_next;
      end
      if (state == EXEC) rsp_data <= alu_out;
    end
  end

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Randomized + directed bench for addsub_rr_arbiter against a transaction-level model.
module tb_addsub_rr_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid, req_ready, req_op, rsp_valid, rsp_ready;
  logic [N*64-1:0]   req_a, req_b;
  logic [63:0]       rsp_data, alu_inA, alu_inB, alu_out;
  logic              alu_control, busy;
  logic [IDW-1:0]    grant_id;

  int n_checks = 0;
  int n_errors = 0;

  // model of the transaction in flight
  bit          m_busy;
  int          m_phase;   // 0: operation accepted last edge, 1: response offered
  int          m_rr, m_gid;
  logic [63:0] m_a, m_b, m_res, m_rsp_data;
  logic        m_op;
  bit          m_just_acc;

  always #5 clk = ~clk;

  assign alu_out = alu_control ? alu_inA + alu_inB : alu_inA - alu_inB;

  addsub_rr_arbiter #(.NUM_REQ(N), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_control(alu_control),
    .alu_out(alu_out), .busy(busy), .grant_id(grant_id)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int rr);
    for (int k = 0; k < N; k++) if (v[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_phase = 0; m_rr = 0; m_gid = 0;
    m_a = '0; m_b = '0; m_op = 1'b0; m_res = '0; m_rsp_data = '0;
  endtask

  task automatic set_req(input int i, input logic op, input logic [63:0] a, input logic [63:0] b);
    req_op[i]         = op;
    req_a[64*i +: 64] = a;
    req_b[64*i +: 64] = b;
  endtask

  // Inputs are driven at posedge+1; outputs checked mid-cycle, then the model advances over the edge.
  task automatic cycle();
    logic [N-1:0] exp_ready, exp_rsp;
    int w;
    #3;
    exp_ready = '0;
    exp_rsp   = '0;
    w = pick(req_valid, m_rr);
    if (!m_busy) begin
      if (w >= 0) exp_ready[w] = 1'b1;
    end else if (m_phase == 1) begin
      exp_rsp[m_gid] = 1'b1;
    end
    check_val("req_ready", req_ready, exp_ready);
    check_val("rsp_valid", rsp_valid, exp_rsp);
    check_val("busy", busy, m_busy);
    check_val("grant_id", grant_id, m_gid);
    check_val("rsp_data", rsp_data, m_rsp_data);
    check_val("alu_inA", alu_inA, m_a);
    check_val("alu_inB", alu_inB, m_b);
    check_val("alu_control", alu_control, m_op);
    m_just_acc = 0;
    if (rst) begin
      model_reset();
    end else if (!m_busy) begin
      if (w >= 0) begin
        m_busy = 1; m_phase = 0; m_gid = w; m_rr = (w + 1) % N;
        m_a  = req_a[64*w +: 64];
        m_b  = req_b[64*w +: 64];
        m_op = req_op[w];
        m_res = m_op ? m_a + m_b : m_a - m_b;
        m_just_acc = 1;
      end
    end else if (m_phase == 0) begin
      m_phase = 1;
      m_rsp_data = m_res;
    end else if (rsp_ready[m_gid]) begin
      m_busy = 0;
    end
    @(posedge clk);
    #1;
  endtask

  int grants[$];
  int grant_cyc[$];
  int cyc;
  int exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = '0; req_op = '0; req_a = '0; req_b = '0;
    @(posedge clk); #1;
    model_reset();
    rst = 1'b0;
    check_val("rst_busy", busy, 0);
    check_val("rst_alu_inA", alu_inA, 0);
    check_val("rst_rsp_valid", rsp_valid, 0);

    // single add from requester 0
    set_req(0, 1'b1, 64'd5, 64'd7);
    req_valid = 4'b0001; rsp_ready = '1;
    cycle();
    check_val("t1_alu_control", alu_control, 1);
    req_valid = '0;
    cycle();
    check_val("t1_rsp_valid", rsp_valid, 4'b0001);
    check_val("t1_sum", rsp_data, 64'd12);
    cycle();

    // subtract and add wrap-around from requester 1
    set_req(1, 1'b0, 64'd0, 64'd1);
    req_valid = 4'b0010;
    cycle(); req_valid = '0; cycle();
    check_val("t2_sub_wrap", rsp_data, 64'hFFFF_FFFF_FFFF_FFFF);
    check_val("t2_rsp_valid", rsp_valid, 4'b0010);
    cycle();
    set_req(1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    req_valid = 4'b0010;
    cycle(); req_valid = '0; cycle();
    check_val("t2_add_wrap", rsp_data, 64'd1);
    cycle();

    // round robin with all requesters valid, starting from reset
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, i[0], 64'd1000 * (i + 1), 64'd3 + i);
    req_valid = '1; rsp_ready = '1;
    grants.delete(); grant_cyc.delete();
    for (int c = 0; c < 15; c++) begin
      cycle();
      if (m_just_acc) begin grants.push_back(int'(grant_id)); grant_cyc.push_back(c); end
    end
    check_val("t3_num_grants", grants.size(), 5);
    for (int i = 0; i < 5 && i < grants.size(); i++) begin
      check_val($sformatf("t3_order%0d", i), grants[i], exp_order[i]);
      if (i > 0) check_val($sformatf("t3_spacing%0d", i), grant_cyc[i] - grant_cyc[i-1], 3);
    end
    req_valid = '0;
    for (int c = 0; c < 3; c++) cycle();

    // backpressure on requester 2; other rsp_ready bits must be ignored
    set_req(2, 1'b1, 64'd100, 64'd23);
    req_valid = 4'b0100; rsp_ready = 4'b1011;
    cycle(); req_valid = 4'b0001; cycle();
    for (int c = 0; c < 10; c++) begin
      check_val("t4_rsp_valid", rsp_valid, 4'b0100);
      check_val("t4_rsp_data", rsp_data, 64'd123);
      check_val("t4_req_ready", req_ready, 4'b0000);
      cycle();
    end
    rsp_ready = '1; req_valid = '0;
    cycle();
    check_val("t4_release_idle", busy, 0);

    // reset during EXEC
    set_req(3, 1'b1, 64'd9, 64'd9);
    req_valid = 4'b1000;
    cycle(); req_valid = '0; rst = 1'b1; cycle(); rst = 1'b0;
    check_val("t5e_busy", busy, 0);
    check_val("t5e_alu_inA", alu_inA, 0);
    check_val("t5e_rsp_data", rsp_data, 0);
    cycle();
    check_val("t5e_no_rsp", rsp_valid, 0);
    req_valid = '1;
    cycle();
    check_val("t5e_regrant0", grant_id, 0);
    req_valid = '0;
    for (int c = 0; c < 3; c++) cycle();

    // reset during RESP
    req_valid = 4'b1000; rsp_ready = '0;
    cycle(); req_valid = '0; cycle();
    check_val("t5r_in_resp", rsp_valid, 4'b1000);
    rst = 1'b1; cycle(); rst = 1'b0; rsp_ready = '1;
    check_val("t5r_no_rsp", rsp_valid, 0);
    check_val("t5r_grant", grant_id, 0);
    req_valid = 4'b1010;
    cycle();
    check_val("t5r_regrant", grant_id, 1);
    req_valid = '0;
    for (int c = 0; c < 3; c++) cycle();

    // operand change after accept
    set_req(0, 1'b1, 64'd10, 64'd1);
    req_valid = 4'b0001;
    cycle();
    req_a[63:0] = 64'd999; req_valid = '0;
    cycle();
    check_val("t6_sampled", rsp_data, 64'd11);
    cycle();

    // randomized traffic with corner operands and occasional reset
    for (int c = 0; c < 2000; c++) begin
      req_valid = N'($urandom);
      rsp_ready = N'($urandom);
      req_op    = N'($urandom);
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 3))
          0: req_a[64*i +: 64] = '0;
          1: req_a[64*i +: 64] = '1;
          default: req_a[64*i +: 64] = {$urandom, $urandom};
        endcase
        case ($urandom_range(0, 3))
          0: req_b[64*i +: 64] = 64'd1;
          1: req_b[64*i +: 64] = '1;
          default: req_b[64*i +: 64] = {$urandom, $urandom};
        endcase
      end
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
